// File: rtl/time_set_controller.sv
// time_set_controller
// Front-panel time-setting controller for a 24-hour BCD clock.
// Pressing mode captures the running time and walks the user through the
// hours, minutes and seconds fields. Increment presses (and auto-repeat
// while the increment button is held) bump only the selected field.
// The final mode press issues a single-cycle Set_time strobe carrying the
// edited time on Time_in. Cancel abandons the edit without a strobe.

module time_set_controller #(
    parameter logic [15:0] REPEAT_DELAY  = 16'd500,
    parameter logic [15:0] REPEAT_PERIOD = 16'd100
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Btn_mode,
    input  logic        Btn_inc,
    input  logic        Btn_cancel,
    input  logic [23:0] Time_now,
    output logic        Set_time,
    output logic [23:0] Time_in,
    output logic        Edit_active,
    output logic [1:0]  Field_sel
);

    // Controller states
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_EDIT_HR  = 3'd1;
    localparam logic [2:0] ST_EDIT_MIN = 3'd2;
    localparam logic [2:0] ST_EDIT_SEC = 3'd3;
    localparam logic [2:0] ST_COMMIT   = 3'd4;

    // Field select encodings presented on Field_sel
    localparam logic [1:0] FIELD_NONE = 2'd0;
    localparam logic [1:0] FIELD_HR   = 2'd1;
    localparam logic [1:0] FIELD_MIN  = 2'd2;
    localparam logic [1:0] FIELD_SEC  = 2'd3;

    // Auto-repeat counter values at which a repeat increment fires. The
    // counter is folded back after each periodic repeat so it never needs
    // to count past the second threshold.
    localparam logic [15:0] RPT_FIRST = REPEAT_DELAY - 16'd1;
    localparam logic [15:0] RPT_NEXT  = RPT_FIRST + REPEAT_PERIOD;

    // State and datapath registers
    logic [2:0]  state_q, state_d;
    logic [23:0] edit_q, edit_d;
    logic        set_time_q, set_time_d;
    logic        edit_active_q, edit_active_d;
    logic [1:0]  field_sel_q, field_sel_d;

    // Button history and "seen low" qualifiers
    logic        btn_mode_q, btn_mode_d;
    logic        btn_inc_q, btn_inc_d;
    logic        btn_cancel_q, btn_cancel_d;
    logic        mode_armed_q, mode_armed_d;
    logic        inc_armed_q, inc_armed_d;
    logic        cancel_armed_q, cancel_armed_d;

    // Auto-repeat counter
    logic [15:0] rpt_cnt_q, rpt_cnt_d;

    // Decoded button events
    logic        press_mode;
    logic        press_inc;
    logic        press_cancel;
    logic        rpt_fire;
    logic        inc_event;

    // Hours increment: 00..23 with wrap; any out-of-range value restarts at 00.
    function automatic logic [7:0] bcd_inc_hours(input logic [7:0] v);
        logic [7:0] r;
        if ((v[3:0] > 4'd9) || (v >= 8'h23)) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Minutes/seconds increment: 00..59 with wrap; invalid digits restart at 00.
    function automatic logic [7:0] bcd_inc_sixty(input logic [7:0] v);
        logic [7:0] r;
        if ((v[3:0] > 4'd9) || (v[7:4] > 4'd5) || (v == 8'h59)) begin
            r = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Edge detection; a button only becomes pressable after it has been seen low
    always_comb begin
        btn_mode_d     = Btn_mode;
        btn_inc_d      = Btn_inc;
        btn_cancel_d   = Btn_cancel;
        mode_armed_d   = mode_armed_q   | ~Btn_mode;
        inc_armed_d    = inc_armed_q    | ~Btn_inc;
        cancel_armed_d = cancel_armed_q | ~Btn_cancel;

        press_mode   = Btn_mode   & ~btn_mode_q   & mode_armed_q;
        press_inc    = Btn_inc    & ~btn_inc_q    & inc_armed_q;
        press_cancel = Btn_cancel & ~btn_cancel_q & cancel_armed_q;
    end

    // Auto-repeat fire decode and combined increment event
    always_comb begin
        rpt_fire = 1'b0;
        if (Btn_inc && inc_armed_q && !press_inc &&
            ((rpt_cnt_q == RPT_FIRST) || (rpt_cnt_q == RPT_NEXT))) begin
            rpt_fire = 1'b1;
        end
        inc_event = press_inc | rpt_fire;
    end

    // Main FSM: cancel beats mode beats increment within a cycle
    always_comb begin
        state_d = state_q;
        edit_d  = edit_q;
        case (state_q)
            ST_IDLE: begin
                if (press_mode && !press_cancel) begin
                    edit_d  = Time_now;
                    state_d = ST_EDIT_HR;
                end
            end
            ST_EDIT_HR: begin
                if (press_cancel) begin
                    state_d = ST_IDLE;
                end else if (press_mode) begin
                    state_d = ST_EDIT_MIN;
                end else if (inc_event) begin
                    edit_d[23:16] = bcd_inc_hours(edit_q[23:16]);
                end
            end
            ST_EDIT_MIN: begin
                if (press_cancel) begin
                    state_d = ST_IDLE;
                end else if (press_mode) begin
                    state_d = ST_EDIT_SEC;
                end else if (inc_event) begin
                    edit_d[15:8] = bcd_inc_sixty(edit_q[15:8]);
                end
            end
            ST_EDIT_SEC: begin
                if (press_cancel) begin
                    state_d = ST_IDLE;
                end else if (press_mode) begin
                    state_d = ST_COMMIT;
                end else if (inc_event) begin
                    edit_d[7:0] = bcd_inc_sixty(edit_q[7:0]);
                end
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Repeat counter runs while the armed increment button is held and
    // restarts on any press, release or state change
    always_comb begin
        rpt_cnt_d = rpt_cnt_q;
        if (!Btn_inc || !inc_armed_q || press_inc || press_mode ||
            press_cancel || (state_d != state_q)) begin
            rpt_cnt_d = 16'd0;
        end else if (rpt_cnt_q == RPT_NEXT) begin
            rpt_cnt_d = RPT_FIRST + 16'd1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 16'd1;
        end
    end

    // Registered output decodes, one cycle behind the state register
    always_comb begin
        set_time_d    = (state_q == ST_COMMIT);
        edit_active_d = 1'b0;
        field_sel_d   = FIELD_NONE;
        case (state_q)
            ST_EDIT_HR: begin
                edit_active_d = 1'b1;
                field_sel_d   = FIELD_HR;
            end
            ST_EDIT_MIN: begin
                edit_active_d = 1'b1;
                field_sel_d   = FIELD_MIN;
            end
            ST_EDIT_SEC: begin
                edit_active_d = 1'b1;
                field_sel_d   = FIELD_SEC;
            end
            default: begin
                edit_active_d = 1'b0;
                field_sel_d   = FIELD_NONE;
            end
        endcase
    end

    // State, edit register, button history and counter update
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q        <= ST_IDLE;
            edit_q         <= 24'h000000;
            set_time_q     <= 1'b0;
            edit_active_q  <= 1'b0;
            field_sel_q    <= FIELD_NONE;
            btn_mode_q     <= 1'b0;
            btn_inc_q      <= 1'b0;
            btn_cancel_q   <= 1'b0;
            mode_armed_q   <= 1'b0;
            inc_armed_q    <= 1'b0;
            cancel_armed_q <= 1'b0;
            rpt_cnt_q      <= 16'd0;
        end else begin
            state_q        <= state_d;
            edit_q         <= edit_d;
            set_time_q     <= set_time_d;
            edit_active_q  <= edit_active_d;
            field_sel_q    <= field_sel_d;
            btn_mode_q     <= btn_mode_d;
            btn_inc_q      <= btn_inc_d;
            btn_cancel_q   <= btn_cancel_d;
            mode_armed_q   <= mode_armed_d;
            inc_armed_q    <= inc_armed_d;
            cancel_armed_q <= cancel_armed_d;
            rpt_cnt_q      <= rpt_cnt_d;
        end
    end

    assign Set_time    = set_time_q;
    assign Time_in     = edit_q;
    assign Edit_active = edit_active_q;
    assign Field_sel   = field_sel_q;

endmodule

// File: tb/tb_time_set_controller.sv
// tb_time_set_controller
// Scoreboard bench: the stimulus side keeps an operation-level model of the
// time-setting session and queues the time it expects to see committed; a
// separate monitor pops that queue whenever Set_time is seen high.

module tb_time_set_controller;

    localparam logic [15:0] DELAY  = 16'd4;
    localparam logic [15:0] PERIOD = 16'd2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        Btn_mode;
    logic        Btn_inc;
    logic        Btn_cancel;
    logic [23:0] Time_now;
    logic        Set_time;
    logic [23:0] Time_in;
    logic        Edit_active;
    logic [1:0]  Field_sel;

    typedef enum int {OP_MODE, OP_INC, OP_CANCEL, OP_MODE_INC, OP_CANCEL_MODE} op_e;
    typedef struct {
        op_e op;
        int  n;
    } op_t;

    op_t         op_list[$];
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;
    int          checks = 0;
    int          failures = 0;
    int          model_field;
    logic [23:0] model_time;

    time_set_controller #(
        .REPEAT_DELAY (DELAY),
        .REPEAT_PERIOD(PERIOD)
    ) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Btn_mode   (Btn_mode),
        .Btn_inc    (Btn_inc),
        .Btn_cancel (Btn_cancel),
        .Time_now   (Time_now),
        .Set_time   (Set_time),
        .Time_in    (Time_in),
        .Edit_active(Edit_active),
        .Field_sel  (Field_sel)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference rules: field value as a number, wrap at limit, invalid -> 0
    function automatic logic [7:0] modelInc(input logic [7:0] bcd, input int limit);
        int tens;
        int units;
        int value;
        tens  = int'(bcd[7:4]);
        units = int'(bcd[3:0]);
        value = tens * 10 + units;
        if (units > 9 || value >= limit) value = 0;
        else value = (value + 1) % limit;
        return {4'(value / 10), 4'(value % 10)};
    endfunction

    function automatic logic [23:0] applyInc(input logic [23:0] t, input int field);
        logic [23:0] r;
        r = t;
        case (field)
            1: r[23:16] = modelInc(t[23:16], 24);
            2: r[15:8]  = modelInc(t[15:8], 60);
            3: r[7:0]   = modelInc(t[7:0], 60);
            default: r = t;
        endcase
        return r;
    endfunction

    // Increments produced by holding inc for n cycles: the press plus one
    // repeat at hold-cycle DELAY and every PERIOD cycles after that
    function automatic int holdEvents(input int n);
        int r;
        r = 1;
        if (n - 1 >= int'(DELAY)) r += (n - 1 - int'(DELAY)) / int'(PERIOD) + 1;
        return r;
    endfunction

    function automatic logic [7:0] toBcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge CLK) begin
        if (!Reset && Set_time) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_strobe: got Set_time=1 Time_in=%h, expected no strobe", Time_in);
            end else begin
                mon_exp = exp_q.pop_front();
                checkOutput("commit_time_in", {8'h0, Time_in}, {8'h0, mon_exp});
                checkOutput("commit_edit_active", {31'h0, Edit_active}, 32'h0);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drivePulse(input logic m, input logic i, input logic c);
        Btn_mode   = m;
        Btn_cancel = c;
        if (i) Btn_inc = 1'b1;
        tick();
        Btn_mode   = 1'b0;
        Btn_cancel = 1'b0;
        if (i) Btn_inc = 1'b0;
        tick();
    endtask

    task automatic holdInc(input int n);
        Btn_inc = 1'b1;
        repeat (n) tick();
        Btn_inc = 1'b0;
        tick();
    endtask

    task automatic waitDrain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 6) begin
            tick();
            k++;
        end
        checkOutput("strobe_seen", {31'h0, exp_q.size() == 0}, 32'h1);
        exp_q.delete();
    endtask

    task automatic addOp(input op_e op, input int n);
        op_t t;
        t.op = op;
        t.n  = n;
        op_list.push_back(t);
    endtask

    task automatic doOp(input op_t o);
        logic commit;
        case (o.op)
            OP_MODE, OP_MODE_INC: begin
                commit = (model_field == 3);
                if (commit) exp_q.push_back(model_time);
                drivePulse(1'b1, o.op == OP_MODE_INC, 1'b0);
                if (model_field == 0) begin
                    model_time  = Time_now;
                    model_field = 1;
                end else if (model_field < 3) begin
                    model_field++;
                end else begin
                    model_field = 0;
                end
                if (commit) begin
                    checkOutput("set_time_rise", {31'h0, Set_time}, 32'h1);
                    waitDrain();
                    checkOutput("set_time_fall", {31'h0, Set_time}, 32'h0);
                end
            end
            OP_INC: begin
                holdInc(o.n);
                if (model_field != 0) begin
                    for (int k = 0; k < holdEvents(o.n); k++) model_time = applyInc(model_time, model_field);
                end
            end
            default: begin
                drivePulse(o.op == OP_CANCEL_MODE, 1'b0, 1'b1);
                model_field = 0;
            end
        endcase
        checkOutput("field_sel", {30'h0, Field_sel}, model_field);
        checkOutput("edit_active", {31'h0, Edit_active}, {31'h0, model_field != 0});
    endtask

    task automatic applyStimulus(input logic [23:0] now);
        Time_now = now;
        foreach (op_list[i]) doOp(op_list[i]);
        op_list.delete();
    endtask

    task automatic doReset(input logic inc_level);
        Reset   = 1'b1;
        Btn_inc = inc_level;
        repeat (2) tick();
        Reset = 1'b0;
        model_field = 0;
        model_time  = 24'h000000;
        tick();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] now;
        logic        cancelled;
        int          r;
        Reset      = 1'b1;
        Btn_mode   = 1'b0;
        Btn_inc    = 1'b0;
        Btn_cancel = 1'b0;
        Time_now   = 24'h000000;
        model_field = 0;
        model_time  = 24'h000000;

        // Reset state with all buttons low
        repeat (2) tick();
        checkOutput("reset_set_time", {31'h0, Set_time}, 32'h0);
        checkOutput("reset_time_in", {8'h0, Time_in}, 32'h0);
        checkOutput("reset_field_sel", {30'h0, Field_sel}, 32'h0);
        checkOutput("reset_edit_active", {31'h0, Edit_active}, 32'h0);
        Reset = 1'b0;
        tick();

        // Reset in the middle of minute editing
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        applyStimulus(24'h112233);
        Reset = 1'b1;
        #1;
        checkOutput("midreset_field_sel", {30'h0, Field_sel}, 32'h0);
        checkOutput("midreset_edit_active", {31'h0, Edit_active}, 32'h0);
        checkOutput("midreset_time_in", {8'h0, Time_in}, 32'h0);
        doReset(1'b0);

        // Basic edit session
        addOp(OP_MODE, 0);
        for (int k = 0; k < 3; k++) addOp(OP_INC, 1);
        addOp(OP_MODE, 0);
        addOp(OP_INC, 1);
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        applyStimulus(24'h123456);

        // Field wrap and digit carry within a field
        foreach (op_list[i]) ;
        for (int f = 0; f < 3; f++) begin
            addOp(OP_MODE, 0);
            addOp(OP_INC, 1);
        end
        addOp(OP_MODE, 0);
        applyStimulus(24'h235959);
        for (int f = 0; f < 3; f++) begin
            addOp(OP_MODE, 0);
            addOp(OP_INC, 1);
        end
        addOp(OP_MODE, 0);
        applyStimulus(24'h090909);

        // Cancel keeps the edited value and produces no strobe
        addOp(OP_MODE, 0);
        addOp(OP_INC, 1);
        addOp(OP_INC, 1);
        addOp(OP_CANCEL, 0);
        applyStimulus(24'h080000);
        checkOutput("cancel_time_in", {8'h0, Time_in}, 32'h00100000);

        // Held increment on seconds: press plus auto-repeats
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        addOp(OP_INC, 10);
        addOp(OP_MODE, 0);
        applyStimulus(24'h000000);

        // Simultaneous mode and increment in hours: increment dropped
        addOp(OP_MODE, 0);
        addOp(OP_MODE_INC, 0);
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        applyStimulus(24'h071520);

        // Increment held high out of reset must not count until released
        doReset(1'b1);
        Time_now = 24'h141414;
        op_list.delete();
        begin
            op_t m;
            m.op = OP_MODE;
            m.n  = 0;
            doOp(m);
        end
        repeat (12) tick();
        Btn_inc = 1'b0;
        tick();
        addOp(OP_INC, 1);
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        addOp(OP_MODE, 0);
        applyStimulus(24'h141414);

        // Randomised sessions
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(0, 1) == 0) now = 24'($urandom);
            else now = {toBcd($urandom_range(0, 23)), toBcd($urandom_range(0, 59)), toBcd($urandom_range(0, 59))};
            if ($urandom_range(0, 3) == 0) addOp(OP_INC, $urandom_range(1, 10));
            addOp(OP_MODE, 0);
            cancelled = 1'b0;
            for (int f = 0; f < 3; f++) begin
                if (!cancelled) begin
                    r = $urandom_range(0, 2);
                    for (int a = 0; a < r; a++) addOp(OP_INC, $urandom_range(1, 10));
                    r = $urandom_range(0, 11);
                    if (r == 0) begin
                        addOp(OP_CANCEL, 0);
                        cancelled = 1'b1;
                    end else if (r == 1) begin
                        addOp(OP_CANCEL_MODE, 0);
                        cancelled = 1'b1;
                    end else if (r == 2) begin
                        addOp(OP_MODE_INC, 0);
                    end else begin
                        addOp(OP_MODE, 0);
                    end
                end
            end
            applyStimulus(now);
        end

        repeat (3) tick();
        checkOutput("queue_empty", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
